blake2_msg_sched: RTL and testbench
===================================

Name: blake2_msg_sched

Overview:
Front-end scheduler for the blake2 core. It accepts one job (key length, digest length, message length) and a single byte stream carrying the key bytes followed by the message bytes. It cuts the stream into 64-byte blocks, zero-pads the key block and the final block, and drives the core's block_first/block_last/data_idx/ll sequencing. It then captures the core's nn-byte digest burst and forwards it to the requester.

Parameters:
BLK_BYTES, 64, bytes per core block; fixed by the core's 6-bit data index.
LEN_W, 32, width of the message byte-length field.
KN_W, 6, width of the kk/nn fields; matches the core.
LL_W, 128, width of the core ll port.

Ports:
clk  in  1  clock
nreset  in  1  asynchronous active-low reset
start_i  in  1  job start pulse; sampled only in S_IDLE
kk_i  in  KN_W  key bytes, 0..63
nn_i  in  KN_W  digest bytes, 1..63
len_i  in  LEN_W  message bytes, excluding the key
s_valid_i  in  1  stream byte valid
s_data_i  in  8  stream byte: kk key bytes first, then len message bytes
s_ready_o  out  1  stream byte accepted when s_valid_i & s_ready_o
core_ready_i  in  1  core ready_v_o
core_data_v_o  out  1  core data_v_i
core_data_idx_o  out  6  core data_idx_i
core_data_o  out  8  core data_i
core_first_o  out  1  core block_first_i; held for the whole block
core_last_o  out  1  core block_last_i; held for the whole block
core_kk_o  out  KN_W  latched kk
core_nn_o  out  KN_W  latched nn
core_ll_o  out  LL_W  total bytes: len + (kk≠0 ? 64 : 0), zero-extended
core_h_v_i  in  1  core h_v_o
core_h_i  in  8  core h_o
res_v_o  out  1  digest byte valid; no backpressure
res_o  out  8  digest byte
busy_o  out  1  high in every state except S_IDLE
done_o  out  1  one-cycle pulse with the last digest byte

Behaviour:
- One clock. Reset is asynchronous and active-low.
- The core resets synchronously, so nreset must be held across at least one clk edge.
- On reset: all outputs 0, state S_IDLE, all counters 0, latched config 0.
- Core outputs (core_data_v_o, core_data_idx_o, core_data_o, core_first_o, core_last_o) are registered, so each byte reaches the core one cycle after acceptance/generation.
- S_IDLE:
  - On start_i, latch kk/nn/len and compute core_ll_o.
  - Set the remaining-message counter to len.
  - Go to S_KEY if kk≠0; else S_MSG if len≠0; else S_PAD.
- Block flags, evaluated at block start:
  - first = this is block 0.
  - last = (key block & len==0) | (message block & remaining ≤ 64).
  - The unkeyed, len==0 case is a single all-zero block with first=last=1.
- Byte issue: a byte is issued only while core_ready_i=1 and the state is not S_BLK_WAIT. The block byte index idx runs 0..63.
- S_KEY:
  - s_ready_o = core_ready_i; forward stream bytes while idx < kk.
  - At idx==kk go to S_PAD.
- S_MSG:
  - s_ready_o = core_ready_i; forward stream bytes and decrement remaining.
  - When remaining hits 0 mid-block go to S_PAD; at idx==63 go to S_BLK_WAIT.
- S_PAD:
  - s_ready_o=0; issue 0x00 bytes every cycle core_ready_i=1 until idx==63.
- After idx==63 is issued, go to S_BLK_WAIT:
  - Wait for core_ready_i to be seen low, then high again.
  - Then go to S_MSG for the next block, or to S_RES if the block was last.
  - No byte is ever issued between idx 63 and ready re-rising.
- idx wraps 63→0 at each block. remaining never underflows; a stream byte beyond len is not accepted.
- S_RES:
  - The core's h_v burst is nn+1 cycles; the first valid cycle is a lead cycle and is dropped.
  - The next nn valid bytes go to res_v_o/res_o with 1-cycle latency.
  - done_o fires with byte nn, then return to S_IDLE.
- start_i while busy_o=1 is ignored.
- s_valid_i gaps stall the block; the core simply waits.
- Reset mid-operation aborts the job immediately, with no partial digest output.

Decomposition:
- Package blake2_pkg holds:
  - BLK_BYTES and the LAST_IDX=63 constant.
  - State encodings S_IDLE, S_KEY, S_MSG, S_PAD, S_BLK_WAIT, S_RES.
  - KN_W and LL_W.
- One natural sub-module: blake2_res_capture (lead-cycle drop, nn byte counter, res_v/res/done generation).

Test Plan:
- kk=0, nn=32, len=0 → one block, first=last=1, 64 bytes of 0x00, core_ll_o=0; 32 res bytes match the BLAKE2 model of the empty message; done_o on the 32nd byte.
- kk=0, nn=32, len=3 "abc" → one block, bytes 61,62,63 then 61 pads, first=last=1, ll=3; digest matches the model.
- kk=0, len=65 → block0 first=1/last=0 with 64 data bytes; block1 first=0/last=1 with 1 data byte + 63 zeros; ll=65; no byte issued during the ready-low gap between blocks.
- kk=16, nn=32, len=3 → key block: 16 key bytes + 48 zeros, first=1/last=0; message block last=1; ll=67.
- Random s_valid_i gaps with len=130, plus start_i pulsed mid-job → same digest as gap-free; second start ignored; s_ready_o=0 during S_PAD and S_BLK_WAIT.
- nreset asserted at block byte 20, then released → all outputs 0 immediately; a fresh job then completes correctly.

Source files
------------

// File: rtl/blake2_pkg.sv
// Shared constants and state encoding for the BLAKE2 message scheduler.
//   BLK_BYTES : bytes per core block (the core's data index is 6 bits wide)
//   LAST_IDX  : byte index of the final byte in a block
//   KN_W      : width of the key-length / digest-length fields
//   LL_W      : width of the core's total-length port
//   state_t   : scheduler states
package blake2_pkg;
    localparam int         BLK_BYTES = 64;
    localparam logic [5:0] LAST_IDX  = 6'd63;
    localparam int         KN_W      = 6;
    localparam int         LL_W      = 128;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEY      = 3'd1,
        S_MSG      = 3'd2,
        S_PAD      = 3'd3,
        S_BLK_WAIT = 3'd4,
        S_RES      = 3'd5
    } state_t;
endpackage

// File: rtl/blake2_res_capture.sv
// Digest capture: drops the lead cycle of the core's h_v burst, forwards the
// next nn bytes with one cycle of latency and pulses done_o with the last one.
//   clk, nreset : clock, asynchronous active-low reset
//   en_i        : high while the scheduler waits for the digest
//   nn_i        : digest length in bytes (1..63)
//   h_v_i, h_i  : core digest burst
//   res_v_o     : digest byte valid, res_o : digest byte
//   done_o      : pulse with the final digest byte
module blake2_res_capture
    import blake2_pkg::*;
(
    input  logic            clk,
    input  logic            nreset,
    input  logic            en_i,
    input  logic [KN_W-1:0] nn_i,
    input  logic            h_v_i,
    input  logic [7:0]      h_i,
    output logic            res_v_o,
    output logic [7:0]      res_o,
    output logic            done_o
);
    logic            lead_seen_reg;
    logic [KN_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lead_seen_reg <= 1'b0;
            cnt_reg       <= '0;
            res_v_o       <= 1'b0;
            res_o         <= 8'h00;
            done_o        <= 1'b0;
        end else begin
            res_v_o <= 1'b0;
            done_o  <= 1'b0;
            if (!en_i) begin
                lead_seen_reg <= 1'b0;
                cnt_reg       <= '0;
            end else if (h_v_i) begin
                if (!lead_seen_reg) begin
                    // First valid cycle of the burst carries no digest data.
                    lead_seen_reg <= 1'b1;
                end else begin
                    res_v_o <= 1'b1;
                    res_o   <= h_i;
                    if (cnt_reg == nn_i - KN_W'(1)) begin
                        done_o        <= 1'b1;
                        cnt_reg       <= '0;
                        lead_seen_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + KN_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: rtl/blake2_msg_sched.sv
// BLAKE2 core front-end: takes one job (kk, nn, len) plus a byte stream of
// key bytes followed by message bytes, cuts it into zero-padded 64-byte
// blocks with first/last flags, then returns the core's nn-byte digest.
//   clk, nreset        : clock, asynchronous active-low reset
//   start_i, kk_i, nn_i, len_i : job request (sampled in S_IDLE only)
//   s_valid_i, s_data_i, s_ready_o : input byte stream
//   core_ready_i       : core ready; its low-then-high pulse ends a block
//   core_data_v_o/idx_o/data_o/first_o/last_o : registered block bytes
//   core_kk_o, core_nn_o, core_ll_o : latched job configuration
//   core_h_v_i, core_h_i : core digest burst
//   res_v_o, res_o, done_o : digest output, busy_o : job in progress
module blake2_msg_sched
    import blake2_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start_i,
    input  logic [KN_W-1:0]  kk_i,
    input  logic [KN_W-1:0]  nn_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             s_valid_i,
    input  logic [7:0]       s_data_i,
    output logic             s_ready_o,
    input  logic             core_ready_i,
    output logic             core_data_v_o,
    output logic [5:0]       core_data_idx_o,
    output logic [7:0]       core_data_o,
    output logic             core_first_o,
    output logic             core_last_o,
    output logic [KN_W-1:0]  core_kk_o,
    output logic [KN_W-1:0]  core_nn_o,
    output logic [LL_W-1:0]  core_ll_o,
    input  logic             core_h_v_i,
    input  logic [7:0]       core_h_i,
    output logic             res_v_o,
    output logic [7:0]       res_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam logic [LEN_W-1:0] BLK_LEN = LEN_W'(BLK_BYTES);
    localparam logic [LEN_W:0]   BLK_SUM = (LEN_W+1)'(BLK_BYTES);

    state_t           state_reg, state_next;
    logic [5:0]       idx_reg, idx_next;
    logic [LEN_W-1:0] rem_reg, rem_next;
    logic             blk_first_reg, blk_first_next;
    logic             blk_last_reg, blk_last_next;
    logic             seen_low_reg, seen_low_next;
    logic             issue;
    logic [7:0]       issue_data;
    logic             load_cfg;
    logic             cap_en;
    logic [LEN_W:0]   ll_sum;

    // A keyed job prepends one full key block to the byte count.
    assign ll_sum = {1'b0, len_i} + ((kk_i != '0) ? BLK_SUM : '0);
    assign busy_o = (state_reg != S_IDLE);
    assign cap_en = (state_reg == S_RES);

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        rem_next       = rem_reg;
        blk_first_next = blk_first_reg;
        blk_last_next  = blk_last_reg;
        seen_low_next  = seen_low_reg;
        issue          = 1'b0;
        issue_data     = 8'h00;
        load_cfg       = 1'b0;
        s_ready_o      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    load_cfg       = 1'b1;
                    rem_next       = len_i;
                    idx_next       = 6'd0;
                    seen_low_next  = 1'b0;
                    blk_first_next = 1'b1;
                    // Unkeyed empty message still yields one last block.
                    blk_last_next  = (kk_i != '0) ? (len_i == '0) : (len_i <= BLK_LEN);
                    if (kk_i != '0)       state_next = S_KEY;
                    else if (len_i != '0) state_next = S_MSG;
                    else                  state_next = S_PAD;
                end
            end
            S_KEY: begin
                s_ready_o = core_ready_i;
                if (core_ready_i && s_valid_i) begin
                    issue      = 1'b1;
                    issue_data = s_data_i;
                    idx_next   = idx_reg + 6'd1;
                    if (idx_reg == core_kk_o - KN_W'(1)) state_next = S_PAD;
                end
            end
            S_MSG: begin
                s_ready_o = core_ready_i && (rem_reg != '0);
                if (s_ready_o && s_valid_i) begin
                    issue      = 1'b1;
                    issue_data = s_data_i;
                    idx_next   = idx_reg + 6'd1;
                    rem_next   = rem_reg - LEN_W'(1);
                    if (idx_reg == LAST_IDX)          state_next = S_BLK_WAIT;
                    else if (rem_reg == LEN_W'(1))    state_next = S_PAD;
                end
            end
            S_PAD: begin
                if (core_ready_i) begin
                    issue    = 1'b1;
                    idx_next = idx_reg + 6'd1;
                    if (idx_reg == LAST_IDX) state_next = S_BLK_WAIT;
                end
            end
            S_BLK_WAIT: begin
                // The core signals block consumption by dropping ready and
                // raising it again; only then may the next block begin.
                if (!seen_low_reg) begin
                    if (!core_ready_i) seen_low_next = 1'b1;
                end else if (core_ready_i) begin
                    seen_low_next = 1'b0;
                    if (blk_last_reg) begin
                        state_next = S_RES;
                    end else begin
                        state_next     = S_MSG;
                        blk_first_next = 1'b0;
                        blk_last_next  = (rem_reg <= BLK_LEN);
                    end
                end
            end
            S_RES: begin
                if (done_o) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg       <= S_IDLE;
            idx_reg         <= 6'd0;
            rem_reg         <= '0;
            blk_first_reg   <= 1'b0;
            blk_last_reg    <= 1'b0;
            seen_low_reg    <= 1'b0;
            core_kk_o       <= '0;
            core_nn_o       <= '0;
            core_ll_o       <= '0;
            core_data_v_o   <= 1'b0;
            core_data_idx_o <= 6'd0;
            core_data_o     <= 8'h00;
            core_first_o    <= 1'b0;
            core_last_o     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            rem_reg       <= rem_next;
            blk_first_reg <= blk_first_next;
            blk_last_reg  <= blk_last_next;
            seen_low_reg  <= seen_low_next;
            if (load_cfg) begin
                core_kk_o <= kk_i;
                core_nn_o <= nn_i;
                core_ll_o <= LL_W'(ll_sum);
            end
            core_data_v_o <= issue;
            if (issue) begin
                core_data_idx_o <= idx_reg;
                core_data_o     <= issue_data;
                core_first_o    <= blk_first_reg;
                core_last_o     <= blk_last_reg;
            end
        end
    end

    blake2_res_capture u_res_capture (
        .clk     (clk),
        .nreset  (nreset),
        .en_i    (cap_en),
        .nn_i    (core_nn_o),
        .h_v_i   (core_h_v_i),
        .h_i     (core_h_i),
        .res_v_o (res_v_o),
        .res_o   (res_o),
        .done_o  (done_o)
    );
endmodule

// File: tb/tb_blake2_msg_sched.sv
// Scoreboard bench: expected blocks and digest bytes are queued when a job
// is issued; independent monitors compare whatever the DUT presents. A
// simple stand-in core hashes each received block and emits a digest burst.
module tb_blake2_msg_sched;
    import blake2_pkg::*;
    localparam int LEN_W = 32;

    logic             clk = 1'b0;
    logic             nreset;
    logic             start_i;
    logic [KN_W-1:0]  kk_i, nn_i;
    logic [LEN_W-1:0] len_i;
    logic             s_valid_i;
    logic [7:0]       s_data_i;
    logic             s_ready_o;
    logic             cm_ready;
    logic             core_data_v_o;
    logic [5:0]       core_data_idx_o;
    logic [7:0]       core_data_o;
    logic             core_first_o, core_last_o;
    logic [KN_W-1:0]  core_kk_o, core_nn_o;
    logic [LL_W-1:0]  core_ll_o;
    logic             cm_hv;
    logic [7:0]       cm_h;
    logic             res_v_o;
    logic [7:0]       res_o;
    logic             busy_o, done_o;

    always #5 clk = ~clk;

    blake2_msg_sched #(.LEN_W(LEN_W)) dut (
        .clk(clk), .nreset(nreset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i),
        .len_i(len_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .core_ready_i(cm_ready), .core_data_v_o(core_data_v_o),
        .core_data_idx_o(core_data_idx_o), .core_data_o(core_data_o),
        .core_first_o(core_first_o), .core_last_o(core_last_o),
        .core_kk_o(core_kk_o), .core_nn_o(core_nn_o), .core_ll_o(core_ll_o),
        .core_h_v_i(cm_hv), .core_h_i(cm_h), .res_v_o(res_v_o), .res_o(res_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_rst(input string name);
        chk(name, {s_ready_o, core_data_v_o, core_data_idx_o, core_data_o, core_first_o,
                   core_last_o, core_kk_o, core_nn_o, core_ll_o, res_v_o, res_o,
                   busy_o, done_o}, '0);
    endtask

    // Stand-in digest: FNV-style mix of every block byte, seeded by the job.
    function automatic logic [31:0] mix(input logic [31:0] h, input logic [7:0] b);
        return (h ^ {24'h0, b}) * 32'h0100_0193;
    endfunction
    function automatic logic [31:0] hinit(input logic [31:0] ll, input logic [5:0] kk, input logic [5:0] nn);
        return 32'h811c_9dc5 ^ ll ^ {20'h0, kk, nn};
    endfunction
    function automatic logic [7:0] dbyte(input logic [31:0] h, input int i);
        logic [31:0] t;
        t = h >> (8 * (i % 4));
        return t[7:0] ^ i[7:0];
    endfunction

    typedef struct packed {
        logic [511:0] data;
        logic         first;
        logic         last;
        logic [127:0] ll;
        logic [5:0]   kk;
        logic [5:0]   nn;
    } blk_t;
    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } res_t;

    blk_t       exp_blk_q[$];
    res_t       exp_res_q[$];
    logic [7:0] stream[$];

    // ---------------- stand-in core ----------------
    int          cm_cnt, cm_wait, cm_burst, cm_phase;
    int          cm_gap_err = 0;
    logic [31:0] cm_hash;
    logic        cm_last;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cm_ready <= 1'b1; cm_hv <= 1'b0; cm_h <= 8'h00; cm_cnt <= 0;
            cm_wait <= 0; cm_burst <= 0; cm_phase <= 0; cm_hash <= 32'h0; cm_last <= 1'b0;
        end else begin
            cm_hv <= 1'b0;
            if (core_data_v_o && cm_phase != 0) cm_gap_err <= cm_gap_err + 1;
            case (cm_phase)
                0: if (core_data_v_o) begin
                    cm_hash <= mix((core_first_o && cm_cnt == 0) ?
                                   hinit(core_ll_o[31:0], core_kk_o, core_nn_o) : cm_hash,
                                   core_data_o);
                    if (cm_cnt == 63) begin
                        cm_cnt <= 0; cm_ready <= 1'b0; cm_wait <= $urandom_range(2, 5);
                        cm_last <= core_last_o; cm_phase <= 1;
                    end else cm_cnt <= cm_cnt + 1;
                end
                1: if (cm_wait == 0) begin
                    cm_ready <= 1'b1; cm_wait <= 2; cm_phase <= cm_last ? 2 : 0;
                end else cm_wait <= cm_wait - 1;
                2: if (cm_wait == 0) begin
                    cm_phase <= 3; cm_burst <= 0;
                end else cm_wait <= cm_wait - 1;
                3: begin
                    cm_hv <= 1'b1;
                    cm_h  <= (cm_burst == 0) ? 8'hA5 : dbyte(cm_hash, cm_burst - 1);
                    if (cm_burst == int'(core_nn_o)) cm_phase <= 0;
                    else cm_burst <= cm_burst + 1;
                end
                default: cm_phase <= 0;
            endcase
        end
    end

    // ---------------- block monitor ----------------
    int           mon_cnt;
    logic [511:0] mon_data;
    logic         mon_first, mon_last, mon_bad;
    blk_t         mon_e;

    initial begin
        mon_cnt = 0; mon_data = '0; mon_first = 0; mon_last = 0; mon_bad = 0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                mon_cnt = 0;
            end else if (core_data_v_o) begin
                if (mon_cnt == 0) begin
                    mon_first = core_first_o; mon_last = core_last_o; mon_bad = 0; mon_data = '0;
                end
                if (core_data_idx_o != 6'(mon_cnt) || core_first_o != mon_first ||
                    core_last_o != mon_last) mon_bad = 1;
                mon_data[8*mon_cnt +: 8] = core_data_o;
                mon_cnt++;
                if (mon_cnt == 64) begin
                    mon_cnt = 0;
                    chk("blk_expected", exp_blk_q.size() != 0, 1);
                    if (exp_blk_q.size() != 0) begin
                        mon_e = exp_blk_q.pop_front();
                        chk("blk_data", mon_data, mon_e.data);
                        chk("blk_first", mon_first, mon_e.first);
                        chk("blk_last", mon_last, mon_e.last);
                        chk("blk_cfg", {core_ll_o, core_kk_o, core_nn_o}, {mon_e.ll, mon_e.kk, mon_e.nn});
                        chk("blk_idx_flags", mon_bad, 0);
                        $display("block first=%0d last=%0d ll=%0d checked", mon_first, mon_last, core_ll_o);
                    end
                end
            end
        end
    end

    // ---------------- result monitor ----------------
    res_t res_e;
    initial begin
        forever begin
            @(negedge clk);
            if (nreset) begin
                if (res_v_o) begin
                    chk("res_expected", exp_res_q.size() != 0, 1);
                    if (exp_res_q.size() != 0) begin
                        res_e = exp_res_q.pop_front();
                        chk("res_byte", res_o, res_e.b);
                        chk("res_done", done_o, res_e.last);
                    end
                end else if (done_o) begin
                    chk("done_without_byte", done_o, 0);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic push_expect(input int kk, input int nn, input int len);
        blk_t        b;
        res_t        r;
        logic [31:0] h;
        longint      ll;
        int          nmsg;
        ll = longint'(len) + ((kk != 0) ? 64 : 0);
        h  = hinit(ll[31:0], 6'(kk), 6'(nn));
        b.ll = 128'(ll); b.kk = 6'(kk); b.nn = 6'(nn);
        if (kk != 0) begin
            b.data = '0;
            for (int i = 0; i < kk; i++) b.data[8*i +: 8] = stream[i];
            b.first = 1'b1;
            b.last  = (len == 0);
            for (int i = 0; i < 64; i++) h = mix(h, b.data[8*i +: 8]);
            exp_blk_q.push_back(b);
        end
        nmsg = (len == 0) ? ((kk == 0) ? 1 : 0) : (len + 63) / 64;
        for (int j = 0; j < nmsg; j++) begin
            b.data = '0;
            for (int i = 0; i < 64; i++)
                if (j * 64 + i < len) b.data[8*i +: 8] = stream[kk + j * 64 + i];
            b.first = (kk == 0 && j == 0);
            b.last  = (j == nmsg - 1);
            for (int i = 0; i < 64; i++) h = mix(h, b.data[8*i +: 8]);
            exp_blk_q.push_back(b);
        end
        for (int i = 0; i < nn; i++) begin
            r.b = dbyte(h, i);
            r.last = (i == nn - 1);
            exp_res_q.push_back(r);
        end
    endtask

    // ---------------- job driver ----------------
    task automatic run_job(input int kk, input int nn, input int len, input bit gaps,
                           input bit mid_start, input int rst_at, input bit abc);
        int total, idx, mid, cyc, extra;
        bit pulsed, done_seen;
        stream.delete();
        for (int i = 0; i < kk + len; i++)
            stream.push_back((abc && i >= kk) ? 8'(8'h61 + (i - kk)) : 8'($urandom));
        push_expect(kk, nn, len);
        $display("job kk=%0d nn=%0d len=%0d gaps=%0d mid_start=%0d rst_at=%0d", kk, nn, len, gaps, mid_start, rst_at);
        @(negedge clk);
        start_i = 1'b1; kk_i = 6'(kk); nn_i = 6'(nn); len_i = LEN_W'(len);
        @(negedge clk);
        start_i = 1'b0; kk_i = 6'($urandom); nn_i = 6'($urandom); len_i = $urandom;
        total = kk + len; idx = 0; mid = total / 2; pulsed = 0; cyc = 0;
        while (idx < total && cyc < 20000) begin
            if (rst_at >= 0 && idx == rst_at) begin
                nreset = 1'b0;
                #1;
                chk_rst("rst_mid_outputs");
                exp_blk_q.delete(); exp_res_q.delete();
                s_valid_i = 1'b0;
                repeat (2) @(negedge clk);
                nreset = 1'b1;
                return;
            end
            s_valid_i = !(gaps && $urandom_range(0, 2) == 0);
            s_data_i  = stream[idx];
            if (mid_start && !pulsed && idx >= mid) begin
                pulsed = 1; start_i = 1'b1;
                kk_i = 6'($urandom); nn_i = 6'($urandom_range(1, 63)); len_i = $urandom_range(0, 300);
            end
            #1;
            if (s_valid_i && s_ready_o) idx++;
            @(negedge clk);
            start_i = 1'b0;
            cyc++;
        end
        chk("stream_done", idx, total);
        s_valid_i = 1'b1; s_data_i = 8'hEE;
        done_seen = 0; cyc = 0; extra = 0;
        while (!done_seen && cyc < 3000) begin
            #1;
            if (s_ready_o) extra++;
            if (done_o) done_seen = 1;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done_seen, 1);
        chk("no_extra_accept", extra, 0);
        s_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("busy_idle", busy_o, 0);
        chk("blk_q_drained", exp_blk_q.size(), 0);
        chk("res_q_drained", exp_res_q.size(), 0);
        chk("no_issue_in_gap", cm_gap_err, 0);
    endtask

    initial begin
        nreset = 1'b0; start_i = 1'b0; kk_i = '0; nn_i = '0; len_i = '0;
        s_valid_i = 1'b0; s_data_i = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk_rst("reset_outputs");
        @(negedge clk);
        nreset = 1'b1;

        run_job(0, 32, 0, 0, 0, -1, 0);
        run_job(0, 32, 3, 0, 0, -1, 1);
        run_job(0, 20, 65, 0, 0, -1, 0);
        run_job(16, 32, 3, 0, 0, -1, 0);
        run_job(0, 32, 130, 1, 1, -1, 0);
        run_job(0, 32, 100, 0, 0, 20, 0);
        run_job(5, 16, 70, 1, 0, -1, 0);
        run_job(63, 63, 64, 0, 0, -1, 0);
        run_job(1, 1, 128, 1, 0, -1, 0);
        run_job(8, 32, 0, 0, 0, -1, 0);
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(0, 63), $urandom_range(1, 63), $urandom_range(0, 200),
                    1'($urandom_range(0, 1)), 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
